// File: rtl/ysyx_23060221_axi_arbiter.sv
// Two-to-one AXI4 master arbiter: IFU (read-only) and LSU (read/write)
// share one external master port. One whole transaction is granted at a
// time with round-robin priority; response channels route back to the
// granted requester. IDs and responses pass through unchanged.
module ysyx_23060221_axi_arbiter (
    input  logic        clk,
    input  logic        rst,
    // IFU read channels
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,
    // LSU read channels
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,
    // LSU write channels
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_awaddr,
    input  logic [3:0]  lsu_awid,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [1:0]  lsu_bresp,
    output logic [3:0]  lsu_bid,
    // External master port
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic [3:0]  m_rid,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awid,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    input  logic [3:0]  m_bid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IFU_R = 2'd1;
    localparam logic [1:0] S_LSU_R = 2'd2;
    localparam logic [1:0] S_LSU_W = 2'd3;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last_grant;
    logic       w_last_grant_next;

    logic w_in_ifu_r;
    logic w_in_lsu_r;
    logic w_in_lsu_w;
    logic w_ifu_want;
    logic w_lsu_want;
    logic w_rd_done;
    logic w_wr_done;

    assign w_in_ifu_r = (r_state == S_IFU_R);
    assign w_in_lsu_r = (r_state == S_LSU_R);
    assign w_in_lsu_w = (r_state == S_LSU_W);
    assign w_ifu_want = ifu_arvalid;
    assign w_lsu_want = lsu_awvalid | lsu_arvalid;
    assign w_rd_done  = m_rvalid & m_rready & m_rlast;
    assign w_wr_done  = m_bvalid & m_bready;

    // Next-state and round-robin winner selection; only IDLE arbitrates.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_lsu_want && (!w_ifu_want || r_last_grant == GRANT_IFU)) begin
                    // A pending LSU write takes precedence over its read.
                    w_state_next      = lsu_awvalid ? S_LSU_W : S_LSU_R;
                    w_last_grant_next = GRANT_LSU;
                end else if (w_ifu_want) begin
                    w_state_next      = S_IFU_R;
                    w_last_grant_next = GRANT_IFU;
                end
            end
            S_IFU_R, S_LSU_R: begin
                if (w_rd_done) begin
                    w_state_next = S_IDLE;
                end
            end
            S_LSU_W: begin
                if (w_wr_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and grant history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= GRANT_IFU;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Read address channel: payload muxed by grant, valid/ready gated.
    assign m_arvalid   = (w_in_ifu_r & ifu_arvalid) | (w_in_lsu_r & lsu_arvalid);
    assign m_araddr    = w_in_lsu_r ? lsu_araddr  : ifu_araddr;
    assign m_arid      = w_in_lsu_r ? lsu_arid    : ifu_arid;
    assign m_arlen     = w_in_lsu_r ? lsu_arlen   : ifu_arlen;
    assign m_arsize    = w_in_lsu_r ? lsu_arsize  : ifu_arsize;
    assign m_arburst   = w_in_lsu_r ? lsu_arburst : ifu_arburst;
    assign ifu_arready = w_in_ifu_r & m_arready;
    assign lsu_arready = w_in_lsu_r & m_arready;

    // Read data channel: payload broadcast, only the granted side sees valid.
    assign m_rready   = (w_in_ifu_r & ifu_rready) | (w_in_lsu_r & lsu_rready);
    assign ifu_rvalid = w_in_ifu_r & m_rvalid;
    assign lsu_rvalid = w_in_lsu_r & m_rvalid;
    assign ifu_rdata  = m_rdata;
    assign ifu_rresp  = m_rresp;
    assign ifu_rlast  = m_rlast;
    assign ifu_rid    = m_rid;
    assign lsu_rdata  = m_rdata;
    assign lsu_rresp  = m_rresp;
    assign lsu_rlast  = m_rlast;
    assign lsu_rid    = m_rid;

    // Write channels belong to the LSU alone; only the handshakes are gated.
    assign m_awvalid   = w_in_lsu_w & lsu_awvalid;
    assign m_awaddr    = lsu_awaddr;
    assign m_awid      = lsu_awid;
    assign m_awlen     = lsu_awlen;
    assign m_awsize    = lsu_awsize;
    assign m_awburst   = lsu_awburst;
    assign lsu_awready = w_in_lsu_w & m_awready;
    assign m_wvalid    = w_in_lsu_w & lsu_wvalid;
    assign m_wdata     = lsu_wdata;
    assign m_wstrb     = lsu_wstrb;
    assign m_wlast     = lsu_wlast;
    assign lsu_wready  = w_in_lsu_w & m_wready;
    assign m_bready    = w_in_lsu_w & lsu_bready;
    assign lsu_bvalid  = w_in_lsu_w & m_bvalid;
    assign lsu_bresp   = m_bresp;
    assign lsu_bid     = m_bid;

endmodule

// File: tb/tb_ysyx_23060221_axi_arbiter.sv
// Directed, table-driven bench for the two-to-one AXI arbiter. Each table
// row is one clock cycle: stimulus applied after the falling edge, outputs
// compared just before the next rising edge.
module tb_ysyx_23060221_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst;
    logic        ifu_rvalid, ifu_rready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic [3:0]  ifu_rid;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_araddr;
    logic [3:0]  lsu_arid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst;
    logic        lsu_rvalid, lsu_rready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rlast;
    logic [3:0]  lsu_rid;
    logic        lsu_awvalid, lsu_awready;
    logic [31:0] lsu_awaddr;
    logic [3:0]  lsu_awid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst;
    logic        lsu_wvalid, lsu_wready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wlast;
    logic        lsu_bvalid, lsu_bready;
    logic [1:0]  lsu_bresp;
    logic [3:0]  lsu_bid;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [3:0]  m_rid;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic [3:0]  m_bid;

    ysyx_23060221_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] IFU_ADDR = 32'h3000_0000;
    localparam logic [31:0] LSU_RADDR = 32'h8000_2000;
    localparam logic [31:0] LSU_WADDR = 32'h8000_1000;
    localparam logic [31:0] LSU_WDATA = 32'hDEAD_BEEF;

    // Stimulus bits: {ifu_arv, lsu_arv, lsu_awv, lsu_wv, m_arready, m_rvalid, m_rlast,
    //                 m_awready, m_wready, m_bvalid}
    // Expected bits: {m_arvalid, m_rready, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
    //                 m_awvalid, m_wvalid, m_bready, lsu_awready, lsu_wready, lsu_bvalid}
    localparam logic [11:0] X_IDLE   = 12'b00_00_00_000_000;
    localparam logic [11:0] X_IFU_AR = 12'b11_10_00_000_000;
    localparam logic [11:0] X_IFU_R  = 12'b01_01_00_000_000;
    localparam logic [11:0] X_LSU_AR = 12'b11_00_10_000_000;
    localparam logic [11:0] X_LSU_R  = 12'b01_00_01_000_000;
    localparam logic [11:0] X_W_AW   = 12'b00_00_00_111_100;
    localparam logic [11:0] X_W_W    = 12'b00_00_00_011_010;
    localparam logic [11:0] X_W_BOTH = 12'b00_00_00_111_110;
    localparam logic [11:0] X_W_B    = 12'b00_00_00_001_001;

    typedef struct {
        logic [9:0]  stim;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [11:0] exp_flags;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic [9:0] s, input logic [1:0] br, input logic [31:0] rd,
                       input logic [11:0] ef, input logic [31:0] ea);
        vec_t v;
        v.stim = s; v.bresp = br; v.rdata = rd; v.exp_flags = ef; v.exp_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [9:0] s, input logic [1:0] br, input logic [31:0] rd);
        {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, m_arready, m_rvalid, m_rlast,
         m_awready, m_wready, m_bvalid} = s;
        lsu_wlast = s[6];
        m_bresp   = br;
        m_rdata   = rd;
    endtask

    function automatic logic [11:0] act_flags();
        return {m_arvalid, m_rready, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                m_awvalid, m_wvalid, m_bready, lsu_awready, lsu_wready, lsu_bvalid};
    endfunction

    // Compares handshake flags plus whichever payloads the expected flags make visible.
    task automatic check(input string name, input logic [11:0] ef, input logic [31:0] ea,
                         input logic [31:0] rd, input logic [1:0] br);
        logic ok;
        logic [11:0] af;
        af = act_flags();
        ok = (af === ef);
        if (ef[11] && m_araddr !== ea) ok = 1'b0;
        if (ef[8] && ifu_rdata !== rd) ok = 1'b0;
        if (ef[6] && lsu_rdata !== rd) ok = 1'b0;
        if (ef[0] && lsu_bresp !== br) ok = 1'b0;
        if (ef[5] && (m_awaddr !== LSU_WADDR || m_wdata !== LSU_WDATA || m_wstrb !== 4'hF)) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got flags=%b araddr=%h ifu_rdata=%h lsu_rdata=%h bresp=%0d, want flags=%b araddr=%h rdata=%h bresp=%0d",
                     name, af, m_araddr, ifu_rdata, lsu_rdata, lsu_bresp, ef, ea, rd, br);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        ifu_araddr = IFU_ADDR; ifu_arid = 4'h1; ifu_arlen = 8'd0; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
        lsu_araddr = LSU_RADDR; lsu_arid = 4'h2; lsu_arlen = 8'd3; lsu_arsize = 3'd2; lsu_arburst = 2'd1;
        lsu_awaddr = LSU_WADDR; lsu_awid = 4'h3; lsu_awlen = 8'd0; lsu_awsize = 3'd2; lsu_awburst = 2'd1;
        lsu_wdata = LSU_WDATA; lsu_wstrb = 4'hF;
        ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
        m_rresp = 2'd0; m_rid = 4'h0; m_bid = 4'h3;
        drive(10'b0, 2'd0, 32'h0);

        // Reset state, IFU alone, tie from reset, write with IFU held off.
        add(10'b0000_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1000_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1000_100_000, 0, 0,            X_IFU_AR, IFU_ADDR);
        add(10'b0000_011_000, 0, 32'h0000_0413, X_IFU_R,  0);
        add(10'b0000_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1100_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1100_100_000, 0, 0,            X_LSU_AR, LSU_RADDR);
        add(10'b1000_011_000, 0, 32'h1122_3344, X_LSU_R,  0);
        add(10'b1000_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1000_100_000, 0, 0,            X_IFU_AR, IFU_ADDR);
        add(10'b0000_011_000, 0, 32'h0000_0055, X_IFU_R,  0);
        add(10'b0011_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1011_000_100, 0, 0,            X_W_AW,   0);
        add(10'b1001_000_010, 0, 0,            X_W_W,    0);
        add(10'b1000_000_001, 2'd0, 0,         X_W_B,    0);
        // Tie after an LSU grant goes to the IFU.
        add(10'b1100_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1100_100_000, 0, 0,            X_IFU_AR, IFU_ADDR);
        add(10'b0100_011_000, 0, 32'h0000_0066, X_IFU_R,  0);
        // Four-beat LSU burst with the IFU waiting.
        add(10'b0100_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1100_100_000, 0, 0,            X_LSU_AR, LSU_RADDR);
        add(10'b1000_010_000, 0, 32'hA000_0000, X_LSU_R,  0);
        add(10'b1000_010_000, 0, 32'hA000_0001, X_LSU_R,  0);
        add(10'b1000_010_000, 0, 32'hA000_0002, X_LSU_R,  0);
        add(10'b1000_011_000, 0, 32'hA000_0003, X_LSU_R,  0);
        add(10'b1000_000_000, 0, 0,            X_IDLE,   0);
        add(10'b1000_100_000, 0, 0,            X_IFU_AR, IFU_ADDR);
        add(10'b0000_011_000, 0, 32'h0000_0077, X_IFU_R,  0);
        // LSU aw+ar together: write first (with SLVERR), then read.
        add(10'b0111_000_000, 0, 0,            X_IDLE,   0);
        add(10'b0111_000_110, 0, 0,            X_W_BOTH, 0);
        add(10'b0100_000_001, 2'd2, 0,         X_W_B,    0);
        add(10'b0100_000_000, 0, 0,            X_IDLE,   0);
        add(10'b0100_100_000, 0, 0,            X_LSU_AR, LSU_RADDR);
        add(10'b0000_011_000, 0, 32'h0BAD_F00D, X_LSU_R,  0);
        add(10'b0000_000_000, 0, 0,            X_IDLE,   0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stim, vecs[i].bresp, vecs[i].rdata);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_flags, vecs[i].exp_addr,
                  vecs[i].rdata, vecs[i].bresp);
            $display("vec %0d stim=%b flags=%b", i, vecs[i].stim, act_flags());
            @(negedge clk);
        end

        // Reset in the middle of an IFU read.
        drive(10'b1000_000_000, 0, 0);
        @(negedge clk);
        #1;
        check("rst_pre_grant", X_IFU_AR & 12'b1100_0000_0000, IFU_ADDR, 0, 0);
        $display("rst seq: granted flags=%b", act_flags());
        rst = 1'b1;
        drive(10'b0000_010_000, 0, 32'h0000_0099);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_outputs_zero", X_IDLE, 0, 0, 0);
        $display("rst seq: after reset flags=%b", act_flags());

        // Fresh IFU request after reset, bounded wait for the grant.
        drive(10'b1000_100_000, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (m_arvalid && m_arready) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL post_rst_grant: got no m_arvalid within 8 cycles, want grant");
        end else begin
            check("post_rst_ar", X_IFU_AR, IFU_ADDR, 0, 0);
        end
        @(negedge clk);
        drive(10'b0000_011_000, 0, 32'h0000_0413);
        #1;
        check("post_rst_r", X_IFU_R, 0, 32'h0000_0413, 0);
        $display("post-reset read: ifu_rdata=%h", ifu_rdata);
        @(negedge clk);
        drive(10'b0, 0, 0);
        #1;
        check("post_rst_idle", X_IDLE, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
